pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_entry.sv | 20 ++
 rtl/pipe_stage_reg.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: slot-state encoding
// and the occupancy values reported for each state.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } pipe_state_e;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_FULL  = 2'd1;
   localparam logic [1:0] OCC_SKID  = 2'd2;

   // Occupancy value reported for a given state.
   function automatic logic [1:0] occ_of(input pipe_state_e s);
      logic [1:0] occ;
      occ = OCC_EMPTY;
      case (s)
         ST_FULL: occ = OCC_FULL;
         ST_SKID: occ = OCC_SKID;
         default: occ = OCC_EMPTY;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of the stage: a data+ctrl register with load enable.
module pipe_entry #(
   parameter int W = 68
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Capture the incoming entry when loaded; cleared by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid slot,
// global stall, flush, and bubbling of control bits on empty/flush.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | no entry held; out_valid low
// ST_FULL  | head slot valid
// ST_SKID  | head and skid slots valid; input blocked
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = 48,
   parameter int                CTRL_W    = 20,
   parameter logic [CTRL_W-1:0] KILL_MASK = '1,
   parameter int                SKID      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              stall,
   input  logic              flush,
   output logic [1:0]        occupancy
);

   localparam int ENT_W = DATA_W + CTRL_W;

   pipe_state_e      state;
   logic [1:0]       occ_q;
   logic             accept;
   logic             consume;
   logic             head_load;
   logic             skid_load;
   logic [ENT_W-1:0] in_ent;
   logic [ENT_W-1:0] head_d;
   logic [ENT_W-1:0] head_q;
   logic [ENT_W-1:0] skid_q;
   logic [CTRL_W-1:0] head_ctrl;

   // Handshake: rst gating keeps in_ready low while reset is held.
   assign in_ready  = rst && !stall && !flush &&
                      ((SKID != 0) ? (state != ST_SKID)
                                   : ((state == ST_EMPTY) || out_ready));
   assign out_valid = (state != ST_EMPTY) && !flush;
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready && !stall;

   assign in_ent    = {in_data, in_ctrl};

   // Head reloads from input on fill or pass-through, from skid on drain.
   assign head_load = ((state == ST_EMPTY) && accept) ||
                      ((state == ST_FULL)  && accept && consume) ||
                      ((state == ST_SKID)  && consume);
   assign head_d    = (state == ST_SKID) ? skid_q : in_ent;
   assign skid_load = (state == ST_FULL) && accept && !consume;

   pipe_entry #(.W(ENT_W)) u_head (
      .clk  (clk),
      .rst  (rst),
      .load (head_load),
      .d    (head_d),
      .q    (head_q)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_entry #(.W(ENT_W)) u_skid (
            .clk  (clk),
            .rst  (rst),
            .load (skid_load),
            .d    (in_ent),
            .q    (skid_q)
         );
      end else begin : g_no_skid
         assign skid_q = '0;
      end
   endgenerate

   // Slot-state machine; occupancy is registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_EMPTY;
         occ_q <= OCC_EMPTY;
      end else if (flush) begin
         state <= ST_EMPTY;
         occ_q <= OCC_EMPTY;
      end else if (!stall) begin
         unique case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state <= ST_FULL;
                  occ_q <= occ_of(ST_FULL);
               end
            end
            ST_FULL: begin
               if (accept && !consume && (SKID != 0)) begin
                  state <= ST_SKID;
                  occ_q <= occ_of(ST_SKID);
               end else if (!accept && consume) begin
                  state <= ST_EMPTY;
                  occ_q <= occ_of(ST_EMPTY);
               end
            end
            ST_SKID: begin
               if (consume) begin
                  state <= ST_FULL;
                  occ_q <= occ_of(ST_FULL);
               end
            end
            default: begin
               state <= ST_EMPTY;
               occ_q <= OCC_EMPTY;
            end
         endcase
      end
   end

   assign head_ctrl = head_q[CTRL_W-1:0];
   assign out_data  = head_q[ENT_W-1:CTRL_W];
   assign out_ctrl  = out_valid ? head_ctrl : (head_ctrl & ~KILL_MASK);
   assign occupancy = occ_q;

endmodule
